// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: shadow-configured pattern of 1..MAX_LEN bits,
// overlapping/non-overlapping matching, registered hit pulse, saturating hit counter, match progress.

// Compares the newest K history bits against the first K pattern bits (pattern[len-1 -: K]).
module seq_detector_prefix_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int K       = 1
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);
  localparam logic [MAX_LEN-1:0] MASK = {MAX_LEN{1'b1}} >> (MAX_LEN - K);

  logic [LEN_W-1:0]   sh;
  logic [MAX_LEN-1:0] pat_sh;

  always_comb begin
    sh     = len - LEN_W'(K);
    pat_sh = pat >> sh;
    eq     = (LEN_W'(K) <= len) && ((hist & MASK) == (pat_sh & MASK));
  end
endmodule

module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               x_valid,
  input  logic               x,
  input  logic               clr_cnt,
  output logic               y,
  output logic [LEN_W-1:0]   match_len,
  output logic [CNT_W-1:0]   hit_cnt
);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   mlen_q, mlen_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN:1]   eq;
  logic [MAX_LEN:0]   eq_ext;
  logic               hit;
  logic [LEN_W-1:0]   best;

  // Candidate history/fill if the current bit is accepted
  always_comb begin
    hist_n = {hist_q[MAX_LEN-2:0], x};
    fill_n = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
  end

  for (genvar k = 1; k <= MAX_LEN; k++) begin : g_cmp
    seq_detector_prefix_cmp #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .K       (k)
    ) u_cmp (
      .hist (hist_n),
      .pat  (pat_q),
      .len  (len_q),
      .eq   (eq[k])
    );
  end

  // Full match is the length-L prefix; progress is the longest proper prefix seen
  always_comb begin
    eq_ext = {eq, 1'b1};
    hit    = (len_q != '0) && (fill_n >= len_q) && eq_ext[len_q];
    best   = '0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((LEN_W'(k) < len_q) && (LEN_W'(k) <= fill_n) && eq[k]) best = LEN_W'(k);
    end
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    mlen_d = mlen_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      pat_d  = pattern;
      len_d  = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
      ovl_d  = overlap;
      hist_d = '0;
      fill_d = '0;
      mlen_d = '0;
    end else if (x_valid) begin
      hist_d = hist_n;
      y_d    = hit;
      fill_d = (hit && !ovl_q) ? '0 : fill_n;
      mlen_d = (hit && !ovl_q) ? '0 : best;
    end
    if (clr_cnt)                                 cnt_d = '0;
    else if (y_d && (cnt_q != {CNT_W{1'b1}}))    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      mlen_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      mlen_q <= mlen_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y         = y_q;
  assign match_len = mlen_q;
  assign hit_cnt   = cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Vector/scoreboard bench for seq_detector_param (MAX_LEN=8, CNT_W=2 to reach saturation quickly).
module tb_seq_detector_param;
  typedef struct {
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       xv;
    logic       x;
    logic       clr;
    logic       ey;
    logic [3:0] eml;
    logic [1:0] ecnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic       overlap = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       y;
  logic [3:0] match_len;
  logic [1:0] hit_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tbl[$];
  vec_t exp_v;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .x_valid   (x_valid),
    .x         (x),
    .clr_cnt   (clr_cnt),
    .y         (y),
    .match_len (match_len),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  // Config vector: load, clear counter; expects everything zero afterwards
  function automatic vec_t c(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic xv, input logic xb);
    vec_t r;
    r.cl = 1'b1; r.pat = p; r.len = l; r.ovl = o; r.xv = xv; r.x = xb; r.clr = 1'b1;
    r.ey = 1'b0; r.eml = 4'd0; r.ecnt = 2'd0;
    return r;
  endfunction

  // Data vector: config inputs carry junk that must not leak in without cfg_load
  function automatic vec_t d(input logic xv, input logic xb, input logic clr, input logic ey,
                             input logic [3:0] eml, input logic [1:0] ecnt);
    vec_t r;
    r.cl = 1'b0; r.pat = 8'h3C; r.len = 4'd2; r.ovl = 1'b0; r.xv = xv; r.x = xb; r.clr = clr;
    r.ey = ey; r.eml = eml; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    cfg_load = v.cl; pattern = v.pat; pat_len = v.len; overlap = v.ovl;
    x_valid = v.xv; x = v.x; clr_cnt = v.clr;
    sb.push_back(v);
  endtask

  task automatic idle();
    cfg_load = 1'b0; x_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (y !== 1'b0 || match_len !== 4'd0 || hit_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL %s: y=%0b match_len=%0d hit_cnt=%0d, want all 0", tag, y, match_len, hit_cnt);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      n_vec++;
      if (y !== exp_v.ey || match_len !== exp_v.eml || hit_cnt !== exp_v.ecnt) begin
        n_err++;
        $display("FAIL vec %0d: y=%0b ml=%0d cnt=%0d, want y=%0b ml=%0d cnt=%0d",
                 n_vec, y, match_len, hit_cnt, exp_v.ey, exp_v.eml, exp_v.ecnt);
      end
    end
  end

  initial begin
    // 1011 overlapping: hits after bits 4 and 7
    tbl.push_back(c(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0));
    tbl.push_back(d(1,1,0,0,4'd1,2'd0)); tbl.push_back(d(1,0,0,0,4'd2,2'd0));
    tbl.push_back(d(1,1,0,0,4'd3,2'd0)); tbl.push_back(d(1,1,0,1,4'd1,2'd1));
    tbl.push_back(d(1,0,0,0,4'd2,2'd1)); tbl.push_back(d(1,1,0,0,4'd3,2'd1));
    tbl.push_back(d(1,1,0,1,4'd1,2'd2));
    // 1011 non-overlapping: single hit, window restarts
    tbl.push_back(c(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(d(1,1,0,0,4'd1,2'd0)); tbl.push_back(d(1,0,0,0,4'd2,2'd0));
    tbl.push_back(d(1,1,0,0,4'd3,2'd0)); tbl.push_back(d(1,1,0,1,4'd0,2'd1));
    tbl.push_back(d(1,0,0,0,4'd0,2'd1)); tbl.push_back(d(1,1,0,0,4'd1,2'd1));
    tbl.push_back(d(1,1,0,0,4'd1,2'd1));
    // A5, L=8, with x_valid gaps (junk x during gaps)
    tbl.push_back(c(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0));
    tbl.push_back(d(1,1,0,0,4'd1,2'd0)); tbl.push_back(d(0,0,0,0,4'd1,2'd0));
    tbl.push_back(d(1,0,0,0,4'd2,2'd0)); tbl.push_back(d(1,1,0,0,4'd3,2'd0));
    tbl.push_back(d(0,1,0,0,4'd3,2'd0)); tbl.push_back(d(0,1,0,0,4'd3,2'd0));
    tbl.push_back(d(1,0,0,0,4'd4,2'd0)); tbl.push_back(d(1,0,0,0,4'd5,2'd0));
    tbl.push_back(d(1,1,0,0,4'd6,2'd0)); tbl.push_back(d(1,0,0,0,4'd7,2'd0));
    tbl.push_back(d(0,1,0,0,4'd7,2'd0)); tbl.push_back(d(1,1,0,1,4'd3,2'd1));
    tbl.push_back(d(0,0,0,0,4'd3,2'd1));
    // pat_len=0 disables even an all-zero pattern
    tbl.push_back(c(8'h00, 4'd0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(d(1,0,0,0,4'd0,2'd0)); tbl.push_back(d(1,0,0,0,4'd0,2'd0));
    tbl.push_back(d(1,0,0,0,4'd0,2'd0)); tbl.push_back(d(1,1,0,0,4'd0,2'd0));
    // pat_len=15 clamps to 8
    tbl.push_back(c(8'hFF, 4'd15, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i < 8; i++) tbl.push_back(d(1,1,0,0,4'(i),2'd0));
    tbl.push_back(d(1,1,0,1,4'd0,2'd1)); tbl.push_back(d(1,1,0,0,4'd1,2'd1));
    // cfg_load together with x_valid: the 0 is dropped, so the next 1 cannot hit
    tbl.push_back(c(8'h01, 4'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(d(1,1,0,0,4'd0,2'd0)); tbl.push_back(d(1,0,0,0,4'd1,2'd0));
    tbl.push_back(d(1,1,0,1,4'd0,2'd1));

    #2;
    check_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Saturation at 3, then clear wins over a simultaneous hit
    step(c(8'h01, 4'd1, 1'b1, 1'b0, 1'b0));
    step(d(1,1,0,1,4'd0,2'd1)); step(d(1,1,0,1,4'd0,2'd2));
    step(d(1,1,0,1,4'd0,2'd3)); step(d(1,1,0,1,4'd0,2'd3));
    step(d(1,1,1,1,4'd0,2'd0)); step(d(1,0,0,0,4'd0,2'd0));
    step(d(1,1,0,1,4'd0,2'd1)); step(d(0,0,1,0,4'd0,2'd0));

    // Reset mid-pattern discards progress asynchronously
    step(c(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0));
    step(d(1,1,0,0,4'd1,2'd0)); step(d(1,0,0,0,4'd2,2'd0));
    step(d(1,1,0,0,4'd3,2'd0));
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    check_zero("held_reset");
    reset_n = 1'b1;
    step(c(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0));
    step(d(1,1,0,0,4'd1,2'd0)); step(d(1,0,0,0,4'd2,2'd0));
    step(d(1,1,0,0,4'd3,2'd0));

    @(negedge clk);
    idle();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
